riscv_lsu: RTL
==============

Name: riscv_lsu

Overview:
- Load/store unit: responder side of the core's memory request (req/we/size/addr/wdata) issued for LOAD/STORE instructions.
- Converts byte/half/word requests into word-aligned data-memory transactions with byte enables.
- Stalls the core until memory acknowledges, then sign/zero-extends load data.
- Sits between the processor core and the data memory/peripheral bus.

Parameters:
- TIMEOUT, 16: max cycles in BUSY without mem_ready_i before the access is abandoned with fault.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- core_req_i  in  1  memory access request from core
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU (BU/HU legal for loads only)
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, right-aligned
- core_rd_o  out  32  extended load data
- core_stall_o  out  1  core must hold PC and request inputs
- core_misaligned_o  out  1  one-cycle pulse: misaligned or illegal size; no memory access
- core_fault_o  out  1  one-cycle pulse: access timed out
- mem_req_o  out  1  data-memory request
- mem_we_o  out  1  data-memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  {core_addr_i[31:2], 2'b00}
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  word read data, valid when mem_ready_i=1
- mem_ready_i  in  1  memory completion strobe

Behaviour:
- Reset (async, rst_i=1): state IDLE, wait counter 0, latched offset/size 0. While reset is asserted, mem_req_o, mem_we_o, core_stall_o, core_misaligned_o and core_fault_o are 0; mem_be_o is 0; core_rd_o is 0. Reset during BUSY aborts the access immediately; no completion is reported.
- Check, combinational on core inputs: misaligned = (H/HU and addr[0]) or (W and addr[1:0]!=0). Illegal = size in {3,6,7}, or we=1 with size BU/HU.
- IDLE:
  - core_req_i=1 with misaligned or illegal: pulse core_misaligned_o for that cycle; mem_req_o=0, core_stall_o=0; remain IDLE.
  - core_req_i=1 and legal: mem_req_o=1 and core_stall_o=1 in the same cycle; latch addr[1:0] and size; next state BUSY; counter cleared.
- BUSY:
  - mem_req_o=1 and outputs are driven from the held core inputs; the core keeps them stable while stalled.
  - mem_ready_i=0: core_stall_o=1; counter increments.
  - mem_ready_i=1: core_stall_o=0 in that cycle; core_rd_o valid in that cycle; next state IDLE.
  - Counter reaches TIMEOUT-1 with no ready: core_fault_o pulses, core_stall_o=0, mem_req_o=0 the next cycle; next state IDLE.
  - mem_ready_i in the same cycle as timeout: ready wins; no fault.
- Latency: minimum 2 cycles (request cycle N, ready in N+1). mem_ready_i in IDLE is ignored.
- Back-to-back: a new core_req_i in the cycle after completion starts a new access from IDLE; no bubble is required.
- Byte enables, off = addr[1:0]:
  - B: 4'b0001<<off
  - H: 4'b0011<<off
  - W: 4'b1111
  - Loads drive the same mask, informational only.
- Store data: B = {4{wd[7:0]}}, H = {2{wd[15:0]}}, W = wd.
- Load data, selected by latched offset:
  - B: sign-extend the selected byte.
  - BU: zero-extend the selected byte.
  - H: sign-extend the selected half.
  - HU: zero-extend the selected half.
  - W: mem_rd_i.
  - core_rd_o = 0 except in the completion cycle of a load.
- mem_we_o = core_we_i whenever mem_req_o=1, else 0.

Test Plan:
- Store byte: addr=0x103, size=0, wd=0x000000AB, ready one cycle later -> mem_addr_o=0x100, mem_be_o=4'b1000, mem_wd_o=0xABABABAB, stall 1 then 0.
- Load half signed: addr=0x202, size=1, mem_rd_i=0x8001_1234 with ready after 3 wait cycles -> stall held for 3 cycles, completion-cycle core_rd_o=0xFFFF8001; repeat with size=5 -> 0x00008001.
- Misaligned: load W at addr=0x6, and H at addr=0x1 -> core_misaligned_o pulse, mem_req_o=0, no stall.
- Illegal size: store with size=4 -> core_misaligned_o pulse, mem_req_o=0.
- Timeout: load, mem_ready_i held 0 -> core_fault_o pulses after TIMEOUT=16 cycles, stall drops, mem_req_o=0 the next cycle.
- Ready arriving together with the timeout -> normal completion, no fault.
- Reset mid-access: assert rst_i asynchronously in BUSY -> mem_req_o and core_stall_o fall without a clock edge; after release, a load byte BU at 0x1 with mem_rd_i=0x0000F000 -> core_rd_o=0x000000F0.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core and the data memory.
// Turns byte/half/word core requests into word-aligned memory accesses with
// byte enables, stalls the core until the memory acknowledges, and extends
// the returned load data. A BUSY access with no acknowledge is abandoned
// with a fault after TIMEOUT cycles.
module riscv_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misaligned_o,
    output logic        core_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [1:0]      off_reg;
    logic [2:0]      size_reg;

    logic            misaligned;
    logic            illegal;
    logic            bad_req;
    logic            timeout_hit;
    logic [3:0]      be_calc;
    logic [31:0]     wd_calc;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_data;

    // Request legality, decoded straight from the core inputs.
    always_comb begin
        case (core_size_i)
            3'd0, 3'd1, 3'd2: illegal = 1'b0;
            3'd4, 3'd5:       illegal = core_we_i;   // unsigned sizes only make sense for loads
            default:          illegal = 1'b1;
        endcase
        misaligned = (((core_size_i == 3'd1) || (core_size_i == 3'd5)) && core_addr_i[0])
                   || ((core_size_i == 3'd2) && (core_addr_i[1:0] != 2'b00));
        bad_req    = misaligned || illegal;
    end

    // Byte-lane mask and lane-replicated store data for the current request.
    always_comb begin
        case (core_size_i)
            3'd0, 3'd4: be_calc = 4'b0001 << core_addr_i[1:0];
            3'd1, 3'd5: be_calc = 4'b0011 << core_addr_i[1:0];
            3'd2:       be_calc = 4'b1111;
            default:    be_calc = 4'b0000;
        endcase
        case (core_size_i)
            3'd0:    wd_calc = {4{core_wd_i[7:0]}};
            3'd1:    wd_calc = {2{core_wd_i[15:0]}};
            default: wd_calc = core_wd_i;
        endcase
    end

    // Lane selection and extension of the returned word, using the latched offset/size.
    always_comb begin
        case (off_reg)
            2'd0:    byte_sel = mem_rd_i[7:0];
            2'd1:    byte_sel = mem_rd_i[15:8];
            2'd2:    byte_sel = mem_rd_i[23:16];
            default: byte_sel = mem_rd_i[31:24];
        endcase
        half_sel = off_reg[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (size_reg)
            3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    load_data = {24'h000000, byte_sel};
            3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
            3'd5:    load_data = {16'h0000, half_sel};
            default: load_data = mem_rd_i;
        endcase
    end

    // Ready in the timeout cycle counts as a normal completion.
    assign timeout_hit = (state_reg == BUSY) && !mem_ready_i
                       && (cnt_reg == CW'(TIMEOUT - 1));

    // Core/memory handshake outputs; everything is held low while in reset.
    always_comb begin
        mem_req_o         = 1'b0;
        core_stall_o      = 1'b0;
        core_misaligned_o = 1'b0;
        core_fault_o      = 1'b0;
        core_rd_o         = 32'h0;
        if (!rst_i) begin
            case (state_reg)
                IDLE: begin
                    if (core_req_i) begin
                        if (bad_req) begin
                            core_misaligned_o = 1'b1;
                        end else begin
                            mem_req_o    = 1'b1;
                            core_stall_o = 1'b1;
                        end
                    end
                end
                default: begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        if (!core_we_i) core_rd_o = load_data;
                    end else if (timeout_hit) begin
                        core_fault_o = 1'b1;
                    end else begin
                        core_stall_o = 1'b1;
                    end
                end
            endcase
        end
        mem_we_o = mem_req_o && core_we_i;
        mem_be_o = mem_req_o ? be_calc : 4'b0000;
    end

    assign mem_addr_o = {core_addr_i[31:2], 2'b00};
    assign mem_wd_o   = wd_calc;

    // Access state, wait counter and the lane information needed at completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            off_reg   <= 2'b00;
            size_reg  <= 3'b000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (core_req_i && !bad_req) begin
                        state_reg <= BUSY;
                        cnt_reg   <= '0;
                        off_reg   <= core_addr_i[1:0];
                        size_reg  <= core_size_i;
                    end
                end
                default: begin
                    if (mem_ready_i || timeout_hit) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule
